// File: rtl/baud_pkg.sv
// Shared constants for the fractional baud generator.
// Defaults target 115200 baud x16 from a 100 MHz clock.
package baud_pkg;

    localparam int CLK_HZ = 100_000_000;
    localparam int BAUD   = 115_200;
    localparam int OSR    = 16;
    localparam int DIV_W  = 16;
    localparam int FRAC_W = 4;

    // Divisor in 1/2^FRAC_W clk units, rounded to nearest
    localparam int DIV_Q = (CLK_HZ * (2 ** FRAC_W) + (BAUD * OSR) / 2)
                         / (BAUD * OSR);

    localparam int DEF_INT  = DIV_Q / (2 ** FRAC_W);
    localparam int DEF_FRAC = DIV_Q % (2 ** FRAC_W);

    function automatic int os_width(input int osr);
        return $clog2(osr);
    endfunction

    localparam int OS_W = os_width(OSR);

endpackage

// File: rtl/baud_gen.sv
// Fractional-N oversampling baud generator with glitch-free
// divisor switching on bit boundaries.
module baud_gen #(
    parameter int DIV_W    = baud_pkg::DIV_W,
    parameter int FRAC_W   = baud_pkg::FRAC_W,
    parameter int OSR      = baud_pkg::OSR,
    parameter int DEF_INT  = baud_pkg::DEF_INT,
    parameter int DEF_FRAC = baud_pkg::DEF_FRAC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              load,
    input  logic              restart,
    output logic              os_tick,
    output logic              bit_tick,
    output logic              baud_clk
);

    localparam int OS_W = baud_pkg::os_width(OSR);

    localparam logic [OS_W-1:0]   OS_HALF  = OS_W'(OSR / 2 - 1);
    localparam logic [OS_W-1:0]   OS_LAST  = OS_W'(OSR - 1);
    localparam logic [DIV_W-1:0]  INT_RST  = DIV_W'(DEF_INT);
    localparam logic [FRAC_W-1:0] FRAC_RST = FRAC_W'(DEF_FRAC);
    localparam logic [DIV_W-1:0]  CNT_RST  = DIV_W'(DEF_INT - 1);

    function automatic logic [DIV_W-1:0] clamp_div(
        input logic [DIV_W-1:0] d
    );
        return (d < DIV_W'(2)) ? DIV_W'(2) : d;
    endfunction

    logic [DIV_W-1:0]  act_int_q,  act_int_d;
    logic [FRAC_W-1:0] act_frac_q, act_frac_d;
    logic [DIV_W-1:0]  pend_int_q,  pend_int_d;
    logic [FRAC_W-1:0] pend_frac_q, pend_frac_d;
    logic [DIV_W-1:0]  cnt_q,    cnt_d;
    logic [OS_W-1:0]   os_cnt_q, os_cnt_d;
    logic [FRAC_W-1:0] acc_q,    acc_d;
    logic              os_q,   os_d;
    logic              bit_q,  bit_d;
    logic              baud_q, baud_d;

    logic              hit;
    logic              wrap;
    logic [DIV_W-1:0]  new_int;
    logic [FRAC_W-1:0] new_frac;
    logic [DIV_W-1:0]  sel_int;
    logic [FRAC_W-1:0] sel_frac;
    logic [FRAC_W:0]   acc_sum;
    logic [DIV_W-1:0]  reload;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_int_q   <= INT_RST;
            act_frac_q  <= FRAC_RST;
            pend_int_q  <= INT_RST;
            pend_frac_q <= FRAC_RST;
            cnt_q       <= CNT_RST;
            os_cnt_q    <= '0;
            acc_q       <= '0;
            os_q        <= 1'b0;
            bit_q       <= 1'b0;
            baud_q      <= 1'b0;
        end else begin
            act_int_q   <= act_int_d;
            act_frac_q  <= act_frac_d;
            pend_int_q  <= pend_int_d;
            pend_frac_q <= pend_frac_d;
            cnt_q       <= cnt_d;
            os_cnt_q    <= os_cnt_d;
            acc_q       <= acc_d;
            os_q        <= os_d;
            bit_q       <= bit_d;
            baud_q      <= baud_d;
        end
    end

    // A load landing on the wrap bypasses pending so the next bit uses it
    always_comb begin
        hit      = en && (cnt_q == '0);
        wrap     = (os_cnt_q == OS_LAST);
        new_int  = load ? div_int  : pend_int_q;
        new_frac = load ? div_frac : pend_frac_q;
        sel_int  = (hit && wrap) ? new_int  : act_int_q;
        sel_frac = (hit && wrap) ? new_frac : act_frac_q;
        acc_sum  = {1'b0, acc_q} + {1'b0, sel_frac};
        reload   = clamp_div(sel_int) - DIV_W'(1)
                 + DIV_W'(acc_sum[FRAC_W]);

        act_int_d   = act_int_q;
        act_frac_d  = act_frac_q;
        pend_int_d  = pend_int_q;
        pend_frac_d = pend_frac_q;
        cnt_d       = cnt_q;
        os_cnt_d    = os_cnt_q;
        acc_d       = acc_q;
        os_d        = 1'b0;
        bit_d       = 1'b0;
        baud_d      = baud_q;

        if (load) begin
            pend_int_d  = div_int;
            pend_frac_d = div_frac;
        end

        unique case (1'b1)
            restart: begin
                if (load) begin
                    act_int_d  = div_int;
                    act_frac_d = div_frac;
                end
                cnt_d    = clamp_div(act_int_d) - DIV_W'(1);
                os_cnt_d = '0;
                acc_d    = '0;
                baud_d   = 1'b0;
            end
            (hit && !restart): begin
                cnt_d    = reload;
                acc_d    = acc_sum[FRAC_W-1:0];
                os_cnt_d = os_cnt_q + OS_W'(1);
                os_d     = 1'b1;
                if (wrap) begin
                    bit_d      = 1'b1;
                    act_int_d  = new_int;
                    act_frac_d = new_frac;
                end
                if (wrap || os_cnt_q == OS_HALF)
                    baud_d = ~baud_q;
            end
            (en && !restart && !hit): begin
                cnt_d = cnt_q - DIV_W'(1);
            end
            default: ;
        endcase
    end

    assign os_tick  = os_q;
    assign bit_tick = bit_q;
    assign baud_clk = baud_q;

endmodule

// File: tb/tb_baud_gen.sv
// Self-checking bench for baud_gen: vector table, corner
// sequences and a randomized run against a cycle reference model.
module tb_baud_gen;

    localparam int OSR    = 16;
    localparam int FRAC_W = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] div_int;
    logic [3:0]  div_frac;
    logic        load;
    logic        restart;
    logic        os_tick;
    logic        bit_tick;
    logic        baud_clk;

    baud_gen #(
        .DIV_W(16), .FRAC_W(FRAC_W), .OSR(OSR),
        .DEF_INT(54), .DEF_FRAC(4)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .div_int(div_int), .div_frac(div_frac),
        .load(load), .restart(restart),
        .os_tick(os_tick), .bit_tick(bit_tick),
        .baud_clk(baud_clk)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick(input bit want_bit, input int limit,
                             output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!(want_bit ? bit_tick : os_tick) && n < limit);
    endtask

    function automatic logic [31:0] outs();
        return 32'({os_tick, bit_tick, baud_clk});
    endfunction

    typedef struct {
        int di;
        int df;
        int first;
        int nxt;
        int high;
    } vec_t;

    vec_t vecs[7];

    task automatic run_vec(input vec_t v);
        int t, t1, t2, rise, fall;
        div_int  = 16'(v.di);
        div_frac = 4'(v.df);
        load     = 1'b1;
        restart  = 1'b1;
        en       = 1'b1;
        step();
        load    = 1'b0;
        restart = 1'b0;
        chk("vec_restart_quiet", outs(), 0);
        t = 0; t1 = -1; t2 = -1; rise = -1; fall = -1;
        while (t2 < 0 && t < 4000) begin
            step();
            t++;
            if (baud_clk && rise < 0) rise = t;
            if (!baud_clk && rise >= 0 && fall < 0) fall = t;
            if (bit_tick) begin
                if (t1 < 0) t1 = t;
                else t2 = t;
            end
        end
        chk($sformatf("vec_first_%0d_%0d", v.di, v.df), t1, v.first);
        chk($sformatf("vec_next_%0d_%0d", v.di, v.df),
            (t2 < 0) ? -1 : t2 - t1, v.nxt);
        chk($sformatf("vec_high_%0d_%0d", v.di, v.df),
            fall - rise, v.high);
    endtask

    // Reference model: remaining enabled edges to the next os_tick
    int m_int, m_frac, p_int, p_frac, m_r, m_acc, m_n;
    bit m_bclk, e_os, e_bit;

    function automatic int clampi(input int d);
        return (d < 2) ? 2 : d;
    endfunction

    task automatic model_reset();
        m_int = 54; m_frac = 4; p_int = 54; p_frac = 4;
        m_r = 54; m_acc = 0; m_n = 0; m_bclk = 0;
    endtask

    task automatic model_step();
        e_os = 0;
        e_bit = 0;
        if (restart) begin
            if (load) begin
                p_int = int'(div_int);  p_frac = int'(div_frac);
                m_int = int'(div_int);  m_frac = int'(div_frac);
            end
            m_r = clampi(m_int);
            m_n = 0;
            m_acc = 0;
            m_bclk = 0;
        end else begin
            if (load) begin
                p_int = int'(div_int);
                p_frac = int'(div_frac);
            end
            if (en) begin
                m_r--;
                if (m_r == 0) begin
                    e_os = 1;
                    m_n++;
                    if (m_n == OSR / 2) m_bclk = !m_bclk;
                    if (m_n == OSR) begin
                        m_n = 0;
                        e_bit = 1;
                        m_bclk = !m_bclk;
                        m_int = p_int;
                        m_frac = p_frac;
                    end
                    m_acc += m_frac;
                    m_r = clampi(m_int) + m_acc / (2 ** FRAC_W);
                    m_acc = m_acc % (2 ** FRAC_W);
                end
            end
        end
    endtask

    initial begin
        int n, m, q, rnd_err;
        int exp_p[4];

        vecs[0] = '{54,  4, 867, 868, 434};
        vecs[1] = '{ 1,  0,  32,  32,  16};
        vecs[2] = '{ 0,  0,  32,  32,  16};
        vecs[3] = '{27,  0, 432, 432, 216};
        vecs[4] = '{10,  0, 160, 160,  80};
        vecs[5] = '{ 3,  8,  55,  56,  28};
        vecs[6] = '{ 2, 15,  46,  47,  24};
        exp_p   = '{54, 54, 54, 55};

        rst = 1'b1; en = 1'b0; load = 1'b0; restart = 1'b0;
        div_int = '0; div_frac = '0;
        repeat (3) step();
        chk("rst_state", outs(), 0);

        @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;
        wait_tick(0, 200, n);
        chk("first_os", n, 54);
        for (int i = 0; i < 4; i++) begin
            wait_tick(0, 200, n);
            chk($sformatf("os_period_%0d", i), n, exp_p[i]);
        end

        n = 0;
        while (!baud_clk && n < 2000) begin
            step();
            n++;
        end
        chk("baud_high_seen", 32'(baud_clk), 1);
        #3 rst = 1'b1;
        #1 chk("async_rst_out", outs(), 0);
        q = 0;
        repeat (3) begin
            step();
            if (os_tick || bit_tick || baud_clk) q++;
        end
        chk("rst_hold_quiet", q, 0);
        @(negedge clk);
        rst = 1'b0;
        wait_tick(0, 200, n);
        chk("rst_release_os", n, 54);

        foreach (vecs[i]) run_vec(vecs[i]);

        en = 1'b0; restart = 1'b1; load = 1'b1;
        div_int = 16'd10; div_frac = 4'd0;
        step();
        restart = 1'b0; load = 1'b0;
        chk("restart_en0_quiet", outs(), 0);
        en = 1'b1;
        wait_tick(0, 100, n);
        chk("restart_en0_os", n, 10);

        restart = 1'b1; load = 1'b1;
        step();
        restart = 1'b0; load = 1'b0;
        wait_tick(0, 100, n);
        chk("en_base_os", n, 10);
        repeat (3) step();
        en = 1'b0;
        q = 0;
        repeat (100) begin
            step();
            if (os_tick || bit_tick) q++;
        end
        chk("en0_quiet", q, 0);
        en = 1'b1;
        wait_tick(0, 200, n);
        chk("en_resume_os", 3 + 100 + n, 110);

        restart = 1'b1; load = 1'b1;
        div_int = 16'd10;
        step();
        restart = 1'b0; load = 1'b0;
        wait_tick(1, 400, n);
        chk("midload_prev_bit", n, 160);
        n = 0;
        repeat (50) begin
            step();
            n++;
        end
        div_int = 16'd27; load = 1'b1;
        step();
        n++;
        load = 1'b0;
        wait_tick(1, 600, m);
        chk("midload_cur_bit", n + m, 160);
        wait_tick(1, 1000, m);
        chk("midload_next_bit", m, 432);

        restart = 1'b1; load = 1'b1;
        div_int = 16'd10;
        step();
        restart = 1'b0; load = 1'b0;
        repeat (159) step();
        div_int = 16'd4; load = 1'b1;
        step();
        load = 1'b0;
        chk("coincide_bit", 32'(bit_tick), 1);
        wait_tick(1, 400, n);
        chk("coincide_next_bit", n, 64);

        rst = 1'b1;
        model_reset();
        repeat (2) step();
        @(negedge clk);
        rst = 1'b0; en = 1'b1; load = 1'b0; restart = 1'b0;
        rnd_err = 0;
        for (int i = 0; i < 20000 && rnd_err < 20; i++) begin
            @(posedge clk);
            model_step();
            #1;
            if (outs() !== 32'({e_os, e_bit, m_bclk})) rnd_err++;
            chk($sformatf("rnd_cycle_%0d", i), outs(),
                32'({e_os, e_bit, m_bclk}));
            en       = ($urandom_range(0, 9) != 0);
            load     = ($urandom_range(0, 39) == 0);
            restart  = ($urandom_range(0, 199) == 0);
            div_int  = 16'($urandom_range(0, 7));
            div_frac = 4'($urandom_range(0, 15));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/baud_gen.md
BAUD_GEN -- requirements
Module: baud_gen

Interface
REQ-001 Parameter DIV_W, default 16, width of the integer divisor.
REQ-002 Parameter FRAC_W, default 4, width of the fractional divisor (units of 1/2^FRAC_W clk).
REQ-003 Parameter OSR, default 16, oversample ticks per bit; a power of two, at least 4.
REQ-004 Parameter DEF_INT, default 54, integer divisor loaded at reset (100 MHz / (115200*16)).
REQ-005 Parameter DEF_FRAC, default 4, fractional divisor loaded at reset (0.25).
REQ-006 clk  input  1  system clock; all logic on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 en  input  1  count enable.
REQ-009 div_int  input  DIV_W  integer divisor, sampled on load.
REQ-010 div_frac  input  FRAC_W  fractional divisor, sampled on load.
REQ-011 load  input  1  single-cycle strobe that captures div_int/div_frac into the pending register.
REQ-012 restart  input  1  synchronous phase restart.
REQ-013 os_tick  output  1  one-cycle pulse at OSR x baud.
REQ-014 bit_tick  output  1  one-cycle pulse at baud rate.
REQ-015 baud_clk  output  1  registered square wave at baud rate, 50% duty in os_tick units.

Function
REQ-016 Active divisor is div_eff = max(active_int, 2); a loaded integer of 0 or 1 is clamped to 2.
REQ-017 Each os_tick period is div_eff + c clk cycles, where c is the carry out of the FRAC_W-bit accumulator acc <= acc + active_frac, updated once per os_tick.
REQ-018 os_tick is high for exactly one cycle when the period down-counter reaches 0; the counter then reloads with div_eff + c - 1.
REQ-019 os_cnt (log2(OSR) bits) increments on each os_tick and wraps OSR-1 -> 0.
REQ-020 bit_tick is asserted in the same cycle as the os_tick that wraps os_cnt.
REQ-021 baud_clk toggles on the os_tick where os_cnt goes OSR/2-1 -> OSR/2 and on the wrap.
REQ-022 A load captures into the pending divisor; pending becomes active on the next bit_tick boundary, so a bit is never stretched mid-period.
REQ-023 If load and bit_tick coincide, the newly loaded value becomes active for the following bit.
REQ-024 restart clears the period counter to div_eff-1, os_cnt to 0, acc to 0 and baud_clk to 0, and suppresses ticks that cycle.
REQ-025 If load and restart coincide, the loaded divisor becomes active immediately and governs the first period after the restart.
REQ-026 restart takes priority over en.
REQ-027 While en=0, all counters, acc and baud_clk hold their values and os_tick/bit_tick are 0.
REQ-028 On re-enable, counting resumes from the held count with no phase loss.
REQ-029 Average baud period is OSR*div_eff + OSR*active_frac/2^FRAC_W clk cycles, exact over each 2^FRAC_W os_ticks.

Reset
REQ-030 rst asynchronously sets active and pending divisors to DEF_INT/DEF_FRAC, period counter to DEF_INT-1, and os_cnt, acc, os_tick, bit_tick and baud_clk to 0.
REQ-031 With en=1 from reset release, the first os_tick occurs on the div_eff-th rising edge after release.
REQ-032 Asserting rst mid-period aborts the period; no tick is emitted during or at release of rst.

Structure
REQ-033 Package baud_pkg holds OSR, DEF_INT/DEF_FRAC for 115200 baud at 100 MHz, and derived counter widths.
REQ-034 Single module, no sub-module; the output pulses are registered, not combinational.

Verification
REQ-035 Defaults (54, 0.25), en=1 -> os_tick periods repeat 54,54,54,55; bit_tick every 868 cycles; baud_clk high for 434±1 cycles.
REQ-036 Load div_int=1, div_frac=0 -> after the next bit_tick, os_tick every 2 cycles and bit_tick every 32 cycles.
REQ-037 Load 27/0 mid-bit -> the current bit completes at the old rate; the next bit_tick arrives 432 cycles later.
REQ-038 en=0 for 100 cycles mid-period -> no ticks; the next os_tick is 100 cycles later than it would otherwise be.
REQ-039 restart together with load 10/0 -> os_tick 10 cycles later, bit_tick 160 cycles after the restart, baud_clk 0 at the restart.
REQ-040 rst pulse asserted asynchronously between edges -> outputs 0 immediately; first os_tick 54 edges after release.
